// File: rtl/shift_right_unit_pkg.sv
// Shared definitions for the multi-cycle right shifter and the ALU decoder.
// Provides the FSM state enum, the default stage count and the SRL/SRA/ROTR opcodes.
// No logic; constants and types only.
package shifter_pkg;

   localparam int SHR_WIDTH  = 32;
   localparam int SHR_STAGES = $clog2(SHR_WIDTH);

   typedef enum logic [1:0] {
      SHR_IDLE  = 2'd0,
      SHR_SHIFT = 2'd1,
      SHR_DONE  = 2'd2
   } shr_state_t;

   // Right-shift opcodes as seen by the ALU decoder.
   typedef enum logic [1:0] {
      SHR_OP_SRL  = 2'd0,
      SHR_OP_SRA  = 2'd1,
      SHR_OP_ROTR = 2'd2
   } shr_op_t;

endpackage

// File: rtl/shr_stage.sv
// Single combinational right-shift stage: shifts by 2^k when enabled, filling vacated bits.
// Ports: i_data operand, i_k stage index, i_en stage enable (shamt bit k), i_fill fill bit,
//        i_rot selects rotate (vacated bits take the bits shifted out), o_data result.
module shr_stage #(
   parameter int WIDTH = 32,
   parameter int KW    = 3
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [KW-1:0]    i_k,
   input  logic             i_en,
   input  logic             i_fill,
   input  logic             i_rot,
   output logic [WIDTH-1:0] o_data
);

   localparam int AW = $clog2(WIDTH) + 1;

   logic [AW-1:0]    w_amt;
   logic [AW-1:0]    w_ramt;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_wrap;

   always_comb begin
      w_amt     = AW'(1) << i_k;
      // Stage amounts never exceed WIDTH/2, so the wrap distance is always in range.
      w_ramt    = AW'(WIDTH) - w_amt;
      w_shifted = i_data >> w_amt;
      w_mask    = ~({WIDTH{1'b1}} >> w_amt);
      w_wrap    = i_data << w_ramt;
      if (!i_en) begin
         o_data = i_data;
      end else if (i_rot) begin
         o_data = w_shifted | w_wrap;
      end else begin
         o_data = w_shifted | (i_fill ? w_mask : '0);
      end
   end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle SRL/SRA (and ROTR when SHIFT_RIGHT_ROTATE_EN is defined) for the execute stage.
// Ports: in_valid/in_ready/data_in/shamt/arith/rotate request side, out_valid/out_ready/data_out
//        result side, busy status. One shamt bit resolved per cycle, LSB first.
module shift_right_unit
   import shifter_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SHAMT_W   = 6,
   parameter int SKIP_ZERO = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   input  logic               rotate,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   data_out,
   output logic               busy
);

   localparam int STAGES = $clog2(WIDTH);
   localparam int KW     = (STAGES > 1) ? $clog2(STAGES) : 1;

   shr_state_t         r_state;
   shr_state_t         w_state_nxt;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_dout;
   logic [SHAMT_W-1:0] r_shamt;
   logic               r_fill;
   logic [KW-1:0]      r_k;

   logic [WIDTH-1:0]   w_stage;
   logic [WIDTH-1:0]   w_final;
   logic               w_rot;
   logic               w_last;
   logic               w_hi_zero;
   logic               w_skip;
   logic               w_over;
   logic               w_finish;

`ifdef SHIFT_RIGHT_ROTATE_EN
   logic r_rot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rot <= 1'b0;
      end else if (r_state == SHR_IDLE && in_valid) begin
         r_rot <= rotate;
      end
   end

   assign w_rot = r_rot;
`else
   logic w_unused_rotate;
   assign w_unused_rotate = rotate;
   assign w_rot           = 1'b0;
`endif

   shr_stage #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_stage (
      .i_data (r_acc),
      .i_k    (r_k),
      .i_en   (r_shamt[r_k]),
      .i_fill (r_fill),
      .i_rot  (w_rot),
      .o_data (w_stage)
   );

   always_comb begin
      w_last    = (r_k == KW'(STAGES - 1));
      // Remaining stages [STAGES-1:k] contribute nothing when their shamt bits are all zero.
      w_hi_zero = ((r_shamt[STAGES-1:0] >> r_k) == '0);
      w_skip    = (SKIP_ZERO != 0) && w_hi_zero && (!r_shamt[SHAMT_W-1] || w_rot);
      w_finish  = w_last || w_skip;
      // Amounts >= WIDTH flush the whole word to fill; rotation takes the amount modulo WIDTH.
      w_over    = r_shamt[SHAMT_W-1] && !w_rot;
      w_final   = w_over ? {WIDTH{r_fill}} : w_stage;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SHR_IDLE:  if (in_valid)  w_state_nxt = SHR_SHIFT;
         SHR_SHIFT: if (w_finish)  w_state_nxt = SHR_DONE;
         SHR_DONE:  if (out_ready) w_state_nxt = SHR_IDLE;
         default:                  w_state_nxt = SHR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SHR_IDLE;
         r_acc   <= '0;
         r_dout  <= '0;
         r_shamt <= '0;
         r_fill  <= 1'b0;
         r_k     <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            SHR_IDLE: begin
               if (in_valid) begin
                  r_acc   <= data_in;
                  r_shamt <= shamt;
                  r_fill  <= arith & data_in[WIDTH-1];
                  r_k     <= '0;
               end
            end
            SHR_SHIFT: begin
               r_acc <= w_stage;
               r_k   <= r_k + KW'(1);
               // Result register only changes on entry to DONE, so data_out is stable while valid.
               if (w_finish) begin
                  r_dout <= w_final;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == SHR_IDLE);
   assign out_valid = (r_state == SHR_DONE);
   assign busy      = (r_state != SHR_IDLE);
   assign data_out  = r_dout;

endmodule

// File: tb/tb_shift_right_unit.sv
module tb_shift_right_unit;

   localparam int W  = 32;
   localparam int SW = 6;
`ifdef SHIFT_RIGHT_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  data_in;
   logic [SW-1:0] shamt;
   logic          arith;
   logic          rotate;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  data_out;
   logic          busy;

   always #5 clk = ~clk;

   shift_right_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .shamt     (shamt),
      .arith     (arith),
      .rotate    (rotate),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit rnd_bp   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain shift semantics straight from the operation definitions.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] sh,
                                          input logic ar, input logic ro);
      int a;
      if (ro && ROT_EN) begin
         a = int'(sh) % W;
         if (a == 0) return d;
         return (d >> a) | (d << (W - a));
      end
      if (int'(sh) >= W) return ar ? {W{d[W-1]}} : '0;
      if (ar) return W'($signed(d) >>> sh);
      return d >> sh;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every accepted result is compared against the oldest expected value.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got %h expected no output", data_out);
         end else begin
            chk("result", data_out, exp_q.pop_front());
         end
      end
   end

   // Random consumer backpressure during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic ar,
                       input logic ro, output int acc_cyc);
      bit ok;
      ok       = 1'b0;
      acc_cyc  = 0;
      data_in  = d;
      shamt    = sh;
      arith    = ar;
      rotate   = ro;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(model(d, sh, ar, ro));
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0 && in_ready) break;
         @(negedge clk);
      end
      chk("drain_pending", W'(exp_q.size()), '0);
   endtask

   initial begin
      int a1, a2, lat;
      logic [W-1:0] d;
      logic [SW-1:0] sh;

      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, lat;
      logic [W-1:0] bp_exp;

      rst       = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      shamt     = '0;
      arith     = 1'b0;
      rotate    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_in_ready",  W'(in_ready),  W'(1));
      chk("reset_out_valid", W'(out_valid), W'(0));
      chk("reset_busy",      W'(busy),      W'(0));
      chk("reset_data_out",  data_out,      '0);
      rst = 1'b0;
      @(negedge clk);

      // SRL latency and single-cycle valid pulse.
      send(32'h8000_0000, 6'd4, 1'b0, 1'b0, a1);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk("busy_in_shift", W'(busy), W'(1));
         if (out_valid) break;
      end
      chk("srl_latency", W'(lat), W'(6));
      chk("srl_data", data_out, 32'h0800_0000);
      @(negedge clk);
      chk("srl_pulse_end", W'(out_valid), W'(0));

      // SRA / SRL back to back; next accept one IDLE cycle after the result.
      send(32'hF000_0000, 6'd8, 1'b1, 1'b0, a1);
      send(32'hF000_0000, 6'd8, 1'b0, 1'b0, a2);
      chk("b2b_accept_gap", W'(a2 - a1), W'(7));
      wait_idle();

      // Over-range amounts.
      send(32'h8000_0001, 6'b100011, 1'b1, 1'b0, a1);
      send(32'h8000_0001, 6'b100011, 1'b0, 1'b0, a1);
      // Rotate requests (SRL results when the rotate feature is absent).
      send(32'h0000_0001, 6'd1,  1'b0, 1'b1, a1);
      send(32'h0000_0001, 6'd36, 1'b0, 1'b1, a1);
      send(32'h8765_4321, 6'd0,  1'b1, 1'b0, a1);
      wait_idle();

      // Backpressure: hold DONE for 3 cycles with a second request pending.
      out_ready = 1'b0;
      bp_exp    = model(32'hA5A5_0000, 6'd12, 1'b1, 1'b0);
      send(32'hA5A5_0000, 6'd12, 1'b1, 1'b0, a1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk("bp_reach_done", W'(out_valid), W'(1));
      data_in  = 32'h0000_FFFF;
      shamt    = 6'd3;
      arith    = 1'b0;
      rotate   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_out_valid", W'(out_valid), W'(1));
         chk("bp_data_hold", data_out, bp_exp);
         chk("bp_in_ready",  W'(in_ready), W'(0));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'h0000_FFFF, 6'd3, 1'b0, 1'b0, a2);
      chk("bp_second_accept_gap", W'(a2 > a1 + 8), W'(1));
      wait_idle();

      // Reset during SHIFT stage 2.
      send(32'hFFFF_FFFF, 6'd31, 1'b0, 1'b0, a1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_mid_out_valid", W'(out_valid), W'(0));
      chk("rst_mid_data_out",  data_out,      '0);
      chk("rst_mid_in_ready",  W'(in_ready),  W'(1));
      chk("rst_mid_busy",      W'(busy),      W'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(32'h1234_5678, 6'd0, 1'b0, 1'b0, a1);
      wait_idle();

      // Randomized traffic with random consumer stalls.
      rnd_bp = 1'b1;
      for (int n = 0; n < 40; n++) begin
         send($urandom, SW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rnd_bp = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
